// File: rtl/sys_array_feeder.sv
// ---------------------------------------------------------------------------
// sys_array_feeder
//   Buffers one batch of k-steps (an A column plus a B row per step). It then
//   clears the systolic array, streams the buffered steps into it one per
//   cycle, and waits for the array to report completion.
//
//   Sequence: LOAD -> CLR -> STREAM -> DONE -> LOAD. Every output is a
//   register.
//
// Ports
//   clk            : clock; all state changes on its rising edge
//   reset          : asynchronous, active-high reset
//   wr_valid       : producer offers one k-step
//   wr_ready       : feeder accepts the offered k-step (LOAD only)
//   wr_a           : A column, element r at [r*WIDTH +: WIDTH]
//   wr_b           : B row,    element c at [c*WIDTH +: WIDTH]
//   wr_last        : offered k-step closes the batch
//   arr_reset      : one-cycle clear pulse into the array
//   out_a / out_b  : operand stream into the array (zero when not streaming)
//   in_done_flag   : operand stream has ended (held in DONE)
//   calc_done_flag : array result is valid (only honoured in DONE)
//   result_valid   : one-cycle pulse when the array result may be sampled
//   busy           : high in every state except LOAD
// ---------------------------------------------------------------------------
module sys_array_feeder #(
    parameter int WIDTH = 16,
    parameter int ROWS  = 4,
    parameter int COLS  = 16,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ROWS*WIDTH-1:0] wr_a,
    input  logic [COLS*WIDTH-1:0] wr_b,
    input  logic                  wr_last,
    output logic                  arr_reset,
    output logic [ROWS*WIDTH-1:0] out_a,
    output logic [COLS*WIDTH-1:0] out_b,
    output logic                  in_done_flag,
    input  logic                  calc_done_flag,
    output logic                  result_valid,
    output logic                  busy
);

    localparam int AW = ROWS * WIDTH;
    localparam int BW = COLS * WIDTH;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_CLR    = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_idx;

    logic          r_wr_ready;
    logic          r_arr_reset;
    logic [AW-1:0] r_out_a;
    logic [BW-1:0] r_out_b;
    logic          r_in_done;
    logic          r_result_valid;
    logic          r_busy;

    logic [AW-1:0] r_buf_a [DEPTH];
    logic [BW-1:0] r_buf_b [DEPTH];

    logic          w_accept;
    logic          w_final;
    logic [AW-1:0] w_rd_a;
    logic [BW-1:0] w_rd_b;

    assign w_accept = (r_state == S_LOAD) & wr_valid & r_wr_ready;
    // The DEPTH-th entry closes the batch even when wr_last is low.
    assign w_final  = wr_last | (r_cnt == LAST_CNT);

    // Entries at or beyond r_cnt are never read. Because of that, the
    // buffer needs no reset: clearing r_cnt discards its contents.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf_a[r_cnt[IW-1:0]] <= wr_a;
            r_buf_b[r_cnt[IW-1:0]] <= wr_b;
        end
    end

    // r_idx is only used as an address while it is below r_cnt.
    assign w_rd_a = r_buf_a[r_idx[IW-1:0]];
    assign w_rd_b = r_buf_b[r_idx[IW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_LOAD;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_wr_ready     <= 1'b0;
            r_arr_reset    <= 1'b0;
            r_out_a        <= '0;
            r_out_b        <= '0;
            r_in_done      <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    r_wr_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    if (w_accept) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_final) begin
                            r_state     <= S_CLR;
                            r_wr_ready  <= 1'b0;
                            r_arr_reset <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    // Entry 0 is loaded here so that it appears on the
                    // cycle right after the clear pulse.
                    r_arr_reset <= 1'b0;
                    r_out_a     <= w_rd_a;
                    r_out_b     <= w_rd_b;
                    r_idx       <= r_idx + CW'(1);
                    r_state     <= S_STREAM;
                end
                S_STREAM: begin
                    if (r_idx == r_cnt) begin
                        r_out_a   <= '0;
                        r_out_b   <= '0;
                        r_in_done <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_out_a <= w_rd_a;
                        r_out_b <= w_rd_b;
                        r_idx   <= r_idx + CW'(1);
                    end
                end
                S_DONE: begin
                    if (calc_done_flag) begin
                        r_result_valid <= 1'b1;
                        r_in_done      <= 1'b0;
                        r_cnt          <= '0;
                        r_idx          <= '0;
                        r_wr_ready     <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign wr_ready     = r_wr_ready;
    assign arr_reset    = r_arr_reset;
    assign out_a        = r_out_a;
    assign out_b        = r_out_b;
    assign in_done_flag = r_in_done;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;

endmodule

// File: tb/tb_sys_array_feeder.sv
// ---------------------------------------------------------------------------
// tb_sys_array_feeder
//   Directed and random batches for sys_array_feeder. Every accepted k-step
//   is pushed to a scoreboard queue. Entries are popped in order as the
//   feeder streams them out.
// ---------------------------------------------------------------------------
module tb_sys_array_feeder;

    localparam int WIDTH = 16;
    localparam int ROWS  = 4;
    localparam int COLS  = 16;
    localparam int DEPTH = 8;
    localparam int AW    = ROWS * WIDTH;
    localparam int BW    = COLS * WIDTH;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
    } step_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_a = '0;
    logic [BW-1:0] wr_b = '0;
    logic          wr_last = 1'b0;
    logic          arr_reset;
    logic [AW-1:0] out_a;
    logic [BW-1:0] out_b;
    logic          in_done_flag;
    logic          calc_done_flag = 1'b0;
    logic          result_valid;
    logic          busy;

    step_t       sb[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    sys_array_feeder #(
        .WIDTH(WIDTH),
        .ROWS (ROWS),
        .COLS (COLS),
        .DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_a          (wr_a),
        .wr_b          (wr_b),
        .wr_last       (wr_last),
        .arr_reset     (arr_reset),
        .out_a         (out_a),
        .out_b         (out_b),
        .in_done_flag  (in_done_flag),
        .calc_done_flag(calc_done_flag),
        .result_valid  (result_valid),
        .busy          (busy)
    );

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] pat_a(input logic [3:0] s);
        logic [AW-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*WIDTH +: WIDTH] = {4'h0, s, 4'h0, s};
        return v;
    endfunction

    function automatic logic [BW-1:0] pat_b(input logic [3:0] s);
        logic [BW-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*WIDTH +: WIDTH] = {4'h1, s, 4'h1, s};
        return v;
    endfunction

    function automatic logic [AW-1:0] rnd_a();
        logic [AW-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*WIDTH +: WIDTH] = WIDTH'($urandom);
        return v;
    endfunction

    function automatic logic [BW-1:0] rnd_b();
        logic [BW-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*WIDTH +: WIDTH] = WIDTH'($urandom);
        return v;
    endfunction

    // Called at a falling edge. Returns at the falling edge just after the
    // step was accepted, with wr_valid dropped.
    task automatic push_step(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic last);
        int unsigned n;
        wr_valid = 1'b1;
        wr_a     = a;
        wr_b     = b;
        wr_last  = last;
        n = 0;
        while (wr_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk_bit("wr_ready_at_offer", wr_ready, 1'b1);
        sb.push_back({a, b});
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Called at the falling edge after the last step was accepted (edge 0).
    // calc_done_flag is toggled randomly here because it must be ignored.
    task automatic run_stream();
        int unsigned k;
        step_t       e;
        k = sb.size();
        chk_bit("clr_arr_reset", arr_reset, 1'b1);
        chk_bit("clr_busy", busy, 1'b1);
        chk_bit("clr_wr_ready", wr_ready, 1'b0);
        chk_a("clr_out_a", out_a, '0);
        chk_b("clr_out_b", out_b, '0);
        chk_bit("clr_in_done", in_done_flag, 1'b0);
        chk_bit("clr_result_valid", result_valid, 1'b0);
        calc_done_flag = 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int unsigned j = 0; j < k; j++) begin
            e = sb.pop_front();
            chk_a("stream_a", out_a, e.a);
            chk_b("stream_b", out_b, e.b);
            chk_bit("stream_arr_reset", arr_reset, 1'b0);
            chk_bit("stream_in_done", in_done_flag, 1'b0);
            chk_bit("stream_wr_ready", wr_ready, 1'b0);
            chk_bit("stream_result_valid", result_valid, 1'b0);
            calc_done_flag = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        calc_done_flag = 1'b0;
        chk_bit("done_in_done", in_done_flag, 1'b1);
        chk_a("done_out_a", out_a, '0);
        chk_b("done_out_b", out_b, '0);
        chk_bit("done_wr_ready", wr_ready, 1'b0);
        chk_bit("done_busy", busy, 1'b1);
    endtask

    // Holds DONE for 'hold' cycles, then raises calc_done_flag for one edge.
    task automatic done_phase(input int unsigned hold);
        for (int unsigned n = 0; n < hold; n++) begin
            chk_bit("hold_in_done", in_done_flag, 1'b1);
            chk_bit("hold_wr_ready", wr_ready, 1'b0);
            chk_bit("hold_result_valid", result_valid, 1'b0);
            chk_a("hold_out_a", out_a, '0);
            @(negedge clk);
        end
        calc_done_flag = 1'b1;
        @(negedge clk);
        calc_done_flag = 1'b0;
        chk_bit("rv_pulse", result_valid, 1'b1);
        chk_bit("rv_wr_ready", wr_ready, 1'b1);
        chk_bit("rv_busy", busy, 1'b0);
        chk_bit("rv_in_done", in_done_flag, 1'b0);
        chk_bit("rv_arr_reset", arr_reset, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        logic        last;

        // Reset values
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_bit("rst_wr_ready", wr_ready, 1'b0);
        chk_bit("rst_arr_reset", arr_reset, 1'b0);
        chk_bit("rst_in_done", in_done_flag, 1'b0);
        chk_bit("rst_result_valid", result_valid, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_a("rst_out_a", out_a, '0);
        chk_b("rst_out_b", out_b, '0);
        reset = 1'b0;
        chk_bit("rst_rel_wr_ready", wr_ready, 1'b0);
        @(negedge clk);
        chk_bit("first_edge_wr_ready", wr_ready, 1'b1);
        chk_bit("first_edge_busy", busy, 1'b0);

        // Five patterned steps, last on step 5, then a long DONE hold
        for (int s = 1; s <= 5; s++) push_step(pat_a(4'(s)), pat_b(4'(s)), s == 5);
        run_stream();
        done_phase(20);

        // Eight steps without wr_last: the 8th is an implicit last, and a
        // 9th offer stays pending until LOAD resumes
        for (int s = 0; s < 8; s++) push_step(rnd_a(), rnd_b(), 1'b0);
        wr_valid = 1'b1;
        wr_a     = pat_a(4'h9);
        wr_b     = pat_b(4'h9);
        wr_last  = 1'b1;
        run_stream();
        done_phase(3);
        push_step(pat_a(4'h9), pat_b(4'h9), 1'b1);
        run_stream();
        done_phase(0);

        // wr_valid toggling every cycle for a 3-step batch
        for (int s = 0; s < 3; s++) begin
            push_step(rnd_a(), rnd_b(), s == 2);
            if (s < 2) @(negedge clk);
        end
        run_stream();
        done_phase(2);

        // Reset during STREAM at entry 2 of 5
        for (int s = 0; s < 5; s++) push_step(pat_a(4'(s + 10)), pat_b(4'(s + 10)), s == 4);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk_a("pre_reset_entry2_a", out_a, sb[2].a);
        reset = 1'b1;
        #1;
        chk_a("midrst_out_a", out_a, '0);
        chk_b("midrst_out_b", out_b, '0);
        chk_bit("midrst_busy", busy, 1'b0);
        chk_bit("midrst_arr_reset", arr_reset, 1'b0);
        chk_bit("midrst_wr_ready", wr_ready, 1'b0);
        chk_bit("midrst_in_done", in_done_flag, 1'b0);
        chk_bit("midrst_result_valid", result_valid, 1'b0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_bit("post_rst_wr_ready", wr_ready, 1'b1);
        push_step(pat_a(4'hA), pat_b(4'hB), 1'b0);
        push_step(pat_a(4'hC), pat_b(4'hD), 1'b1);
        run_stream();
        done_phase(1);

        // 100 back-to-back random batches
        for (int unsigned bt = 0; bt < 100; bt++) begin
            k = $urandom_range(1, DEPTH);
            for (int unsigned j = 0; j < k; j++) begin
                last = (j == k - 1) && ((k < DEPTH) || ($urandom_range(0, 1) == 1));
                push_step(rnd_a(), rnd_b(), last);
                if (j < k - 1 && $urandom_range(0, 3) == 0) @(negedge clk);
            end
            run_stream();
            done_phase($urandom_range(0, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sys_array_feeder.md
SYS_ARRAY_FEEDER -- requirements
Module: sys_array_feeder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the bits per operand element.
REQ-002 The module SHALL have parameter ROWS, default 4, giving the elements per A column (SYS_HEIGHT*ARR_HEIGHT).
REQ-003 The module SHALL have parameter COLS, default 16, giving the elements per B row (SYS_WIDTH*ARR_WIDTH).
REQ-004 The module SHALL have parameter DEPTH, default 8, giving the maximum number of k-steps buffered per batch.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The module SHALL have port wr_valid, input, 1 bit: the producer offers one k-step (an A column plus a B row).
REQ-008 The module SHALL have port wr_ready, output, 1 bit: the feeder accepts the offered k-step.
REQ-009 The module SHALL have port wr_a, input, ROWS*WIDTH bits: the A column; element r is at [r*WIDTH +: WIDTH].
REQ-010 The module SHALL have port wr_b, input, COLS*WIDTH bits: the B row; element c is at [c*WIDTH +: WIDTH].
REQ-011 The module SHALL have port wr_last, input, 1 bit: the offered k-step is the final one of the batch.
REQ-012 The module SHALL have port arr_reset, output, 1 bit: the clear pulse driven into the systolic array's reset.
REQ-013 The module SHALL have port out_a, output, ROWS*WIDTH bits: connects to the array's in_a.
REQ-014 The module SHALL have port out_b, output, COLS*WIDTH bits: connects to the array's in_b.
REQ-015 The module SHALL have port in_done_flag, output, 1 bit: signals the array that the operand stream has ended.
REQ-016 The module SHALL have port calc_done_flag, input, 1 bit: the array reports that out_c is valid.
REQ-017 The module SHALL have port result_valid, output, 1 bit: a 1-cycle pulse when the array result may be sampled.
REQ-018 The module SHALL have port busy, output, 1 bit: high in every state except LOAD.

Function
REQ-019 The module SHALL implement the FSM LOAD -> CLR -> STREAM -> DONE -> LOAD, with every output registered.
REQ-020 LOAD SHALL drive wr_ready=1 and write each accepted k-step (wr_valid&wr_ready) into buffer[cnt], then increment cnt.
REQ-021 LOAD SHALL go to CLR when the accepted k-step has wr_last=1, or when it is the DEPTH-th entry (implicit last, the same cycle).
REQ-022 When wr_valid=0 in LOAD, the module SHALL hold cnt and stay in LOAD, so an empty batch never starts.
REQ-023 CLR SHALL last exactly 1 cycle with arr_reset=1; arr_reset SHALL be 0 in all other states.
REQ-024 STREAM SHALL present buffer[i] on out_a/out_b for i=0..K-1 (K = batch length), one entry per cycle, in order.
REQ-025 STREAM SHALL keep in_done_flag=0 and SHALL last exactly K cycles.
REQ-026 DONE SHALL drive in_done_flag=1 and out_a/out_b=0, holding both until calc_done_flag is sampled high.
REQ-027 On sampling calc_done_flag=1 in DONE, the module SHALL pulse result_valid for 1 cycle, clear cnt and enter LOAD.
REQ-028 The module SHALL ignore calc_done_flag in LOAD, CLR and STREAM.
REQ-029 out_a/out_b SHALL be 0 in LOAD, CLR and DONE.
REQ-030 wr_ready SHALL be 0 in CLR, STREAM and DONE, so no write may overlap streaming.
REQ-031 Timing: the edge accepting the last k-step is edge 0; arr_reset is high for edges 0..1, entry 0 appears after edge 1, and in_done_flag rises after edge K+1.
REQ-032 cnt and i SHALL be clog2(DEPTH+1) bits wide, and cnt SHALL never exceed DEPTH.
REQ-033 The module SHALL perform no arithmetic on operands: data passes bit-exact.

Reset
REQ-034 While reset=1, asynchronously: state=LOAD, cnt=0, i=0.
REQ-035 While reset=1, asynchronously: wr_ready=0, arr_reset=0, in_done_flag=0, result_valid=0, busy=0, out_a=0, out_b=0.
REQ-036 wr_ready SHALL rise on the first clock edge after reset deasserts.
REQ-037 Reset mid-batch (any state) SHALL discard buffered data, and the next batch SHALL start from entry 0.

Verification
REQ-038 Load K=5 steps (A col i = 16'h0i0i per element, B row i = 16'h1i1i), last on step 5 -> arr_reset is 1 cycle; out_a/out_b show steps 0..4 on 5 consecutive cycles; in_done_flag rises on the next cycle.
REQ-039 Hold calc_done_flag=0 for 20 cycles in DONE -> in_done_flag stays 1, wr_ready stays 0; then calc_done_flag=1 -> exactly 1 result_valid pulse, then LOAD.
REQ-040 Offer 8 steps with wr_last=0 (DEPTH=8) -> the 8th step is accepted as implicit last; a 9th offer sees wr_ready=0 until LOAD resumes.
REQ-041 Toggle wr_valid 1/0 each cycle for a 3-step batch -> exactly 3 entries are stored, in order, with no duplicates.
REQ-042 Assert reset in STREAM at entry 2 of 5 -> all outputs are 0 immediately; a following 2-step batch streams only its own 2 entries.
REQ-043 Run 100 back-to-back batches with K random in 1..8 against an NDP_unit model -> every batch produces exactly one result_valid pulse and stream order is preserved.
